fq_ingress: RTL and testbench

Packet-staging writer on the input side of the fair-queue scheduler. It accepts a single framed 64-bit word stream tagged with a destination channel and buffers each complete packet. It then writes the packet into that channel's input FIFO as one gap-free burst, with the word count in header bits [7:0]. The scheduler reads a whole packet without re-checking empty, so this block guarantees a packet never becomes visible in a FIFO until it is fully written contiguously.

---
 rtl/fq_ingress.sv | 221 ++++++++++++++++++++++
 tb/tb_fq_ingress.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fq_ingress.sv
// fq_ingress: packet-staging writer for the fair-queue scheduler input side.
// Collects one framed 64-bit word stream into a staging RAM, then writes each
// complete packet into its destination channel FIFO as one gap-free burst,
// so a packet is never partially visible to the scheduler.
//
// Optional feature macro: FQ_INGRESS_LEN_CHECK_EN (declared length in the sop
// word [7:0] is checked against the counted length).
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   in_valid_i/in_ready_o    input handshake (transfer = valid & ready)
//   in_sop_i/in_eop_i        packet framing
//   in_chan_i                destination channel (sampled on sop)
//   in_data_i                packet word
//   fifo_wrreq_o             per-channel write strobe
//   fifo_wdata_o             shared write data
//   fifo_usedw_i             per-channel fill level
//   drop_count_o             saturating count of discard events
//   err_o                    one-cycle pulse per discard event
//
// state      | meaning
// S_IDLE     | waiting for a sop word
// S_COLLECT  | storing packet words into staging RAM
// S_WAIT_SPACE | packet complete, waiting for room in the channel FIFO
// S_BURST    | writing len words back-to-back into the FIFO
// S_FLUSH    | discarding an oversize packet until its eop
module fq_ingress #(
    parameter int NUM_IN_LOG2     = 3,
    parameter int MAX_PKT         = 64,
    parameter int FIFO_DEPTH_LOG2 = 9
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           in_valid_i,
    output logic                                           in_ready_o,
    input  logic                                           in_sop_i,
    input  logic                                           in_eop_i,
    input  logic [NUM_IN_LOG2-1:0]                         in_chan_i,
    input  logic [63:0]                                    in_data_i,
    output logic [2**NUM_IN_LOG2-1:0]                      fifo_wrreq_o,
    output logic [63:0]                                    fifo_wdata_o,
    input  logic [2**NUM_IN_LOG2-1:0][FIFO_DEPTH_LOG2:0]   fifo_usedw_i,
    output logic [31:0]                                    drop_count_o,
    output logic                                           err_o
);
    localparam int NCH = 2**NUM_IN_LOG2;
    localparam int AW  = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [31:0] DEPTH = 32'(2**FIFO_DEPTH_LOG2);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WAIT_SPACE, S_BURST, S_FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             wp_q, wp_d, len_q, len_d, rd_q, rd_d;
    logic [NUM_IN_LOG2-1:0] ch_q, ch_d;
    logic                   in_ready_q, in_ready_d;
    logic [NCH-1:0]         wrreq_q, wrreq_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [31:0]            drop_q, drop_d;
    logic                   err_q, err_d;
`ifdef FQ_INGRESS_LEN_CHECK_EN
    logic [7:0]             decl_q, decl_d;
`endif

    logic [63:0]   ram_q [MAX_PKT];
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          xfer, drop;
    logic [31:0]   usedw;
    logic          space_ok;

    assign xfer  = in_valid_i & in_ready_q;
    assign usedw = 32'(fifo_usedw_i[ch_q]);
    // Full-width compare; a level above depth never reads as free space.
    assign space_ok = (usedw <= DEPTH) && ((DEPTH - usedw) >= 32'(len_q));

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        len_d      = len_q;
        rd_d       = rd_q;
        ch_d       = ch_q;
        in_ready_d = in_ready_q;
        wrreq_d    = '0;
        wdata_d    = wdata_q;
        drop       = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
`ifdef FQ_INGRESS_LEN_CHECK_EN
        decl_d     = decl_q;
`endif
        case (state_q)
            S_IDLE, S_COLLECT, S_FLUSH: begin
                in_ready_d = 1'b1;
                if (xfer) begin
                    if (in_sop_i) begin
                        // A sop always restarts collection; an open packet is lost.
                        drop   = (state_q == S_COLLECT);
                        ch_d   = in_chan_i;
                        wp_d   = 8'd1;
                        len_d  = 8'd1;
                        ram_we = 1'b1;
`ifdef FQ_INGRESS_LEN_CHECK_EN
                        decl_d = in_data_i[7:0];
                        if (in_data_i[7:0] > 8'(MAX_PKT)) begin
                            drop    = 1'b1;
                            state_d = in_eop_i ? S_IDLE : S_FLUSH;
                        end else if (in_eop_i) begin
                            if (in_data_i[7:0] != 8'd1) begin
                                drop    = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d    = S_WAIT_SPACE;
                                in_ready_d = 1'b0;
                            end
                        end else begin
                            state_d = S_COLLECT;
                        end
`else
                        if (in_eop_i) begin
                            state_d    = S_WAIT_SPACE;
                            in_ready_d = 1'b0;
                        end else begin
                            state_d = S_COLLECT;
                        end
`endif
                    end else if (state_q == S_COLLECT) begin
                        if (wp_q >= 8'(MAX_PKT)) begin
                            drop    = 1'b1;
                            state_d = in_eop_i ? S_IDLE : S_FLUSH;
                        end else begin
                            ram_we    = 1'b1;
                            ram_waddr = wp_q[AW-1:0];
                            wp_d      = wp_q + 8'd1;
                            if (in_eop_i) begin
                                len_d = wp_q + 8'd1;
`ifdef FQ_INGRESS_LEN_CHECK_EN
                                if (decl_q != wp_q + 8'd1) begin
                                    drop    = 1'b1;
                                    state_d = S_IDLE;
                                end else begin
                                    state_d    = S_WAIT_SPACE;
                                    in_ready_d = 1'b0;
                                end
`else
                                state_d    = S_WAIT_SPACE;
                                in_ready_d = 1'b0;
`endif
                            end
                        end
                    end else if (state_q == S_IDLE) begin
                        drop = 1'b1;
                    end else if (in_eop_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_SPACE: begin
                in_ready_d = 1'b0;
                rd_d       = 8'd0;
                if (space_ok) state_d = S_BURST;
            end
            S_BURST: begin
                wrreq_d[ch_q] = 1'b1;
                // With the length check enabled the declared length equals len,
                // so substituting len leaves the header unchanged.
                wdata_d = (rd_q == 8'd0) ? {ram_q[0][63:8], len_q}
                                         : ram_q[rd_q[AW-1:0]];
                rd_d = rd_q + 8'd1;
                if (rd_q == len_q - 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        err_d  = drop;
        drop_d = (drop && (drop_q != 32'hFFFF_FFFF)) ? drop_q + 32'd1 : drop_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            len_q      <= '0;
            rd_q       <= '0;
            ch_q       <= '0;
            in_ready_q <= 1'b0;
            wrreq_q    <= '0;
            wdata_q    <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
`ifdef FQ_INGRESS_LEN_CHECK_EN
            decl_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            len_q      <= len_d;
            rd_q       <= rd_d;
            ch_q       <= ch_d;
            in_ready_q <= in_ready_d;
            wrreq_q    <= wrreq_d;
            wdata_q    <= wdata_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
`ifdef FQ_INGRESS_LEN_CHECK_EN
            decl_q     <= decl_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) ram_q[ram_waddr] <= in_data_i;
    end

    assign in_ready_o   = in_ready_q;
    assign fifo_wrreq_o = wrreq_q;
    assign fifo_wdata_o = wdata_q;
    assign drop_count_o = drop_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fq_ingress.sv
module tb_fq_ingress;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic             in_ready;
    logic [2:0]       in_chan = '0;
    logic [63:0]      in_data = '0;
    logic [7:0]       wrreq;
    logic [63:0]      wdata;
    logic [7:0][9:0]  usedw = '0;
    logic [31:0]      drop_count;
    logic             err;

    fq_ingress #(.NUM_IN_LOG2(3), .MAX_PKT(64), .FIFO_DEPTH_LOG2(9)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_sop_i(in_sop), .in_eop_i(in_eop), .in_chan_i(in_chan), .in_data_i(in_data),
        .fifo_wrreq_o(wrreq), .fifo_wdata_o(wdata), .fifo_usedw_i(usedw),
        .drop_count_o(drop_count), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] ch; logic [63:0] d; } exp_t;
    exp_t sbq[$];
    int   lenq[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int run = 0, wr_total = 0, err_cnt = 0, first_wr = -1, last_wr = -1;
    int exp_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor: pops one expected word per write, checks burst length
    // and that in_ready reopens right after a burst.
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (err) err_cnt++;
            if (|wrreq) begin
                if (run == 0) first_wr = cyc;
                last_wr = cyc;
                run++;
                wr_total++;
                if (sbq.size() == 0) begin
                    chk("unexpected_write", {56'd0, wrreq}, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("wrreq_onehot", {56'd0, wrreq}, {56'd0, 8'd1 << e.ch});
                    chk("wdata", wdata, e.d);
                    chk("ready_low_in_burst", {63'd0, in_ready}, 64'd0);
                end
            end else if (run > 0) begin
                if (lenq.size() == 0) chk("burst_len_unexpected", 64'(run), 64'd0);
                else chk("burst_len", 64'(run), 64'(lenq.pop_front()));
                chk("ready_after_burst", {63'd0, in_ready}, 64'd1);
                run = 0;
            end
        end
    end

    function automatic logic [7:0] hdr_lo(input int n);
`ifdef FQ_INGRESS_LEN_CHECK_EN
        return 8'(n);
`else
        return 8'hA5;
`endif
    endfunction

    function automatic logic [63:0] word(input int ch, input int p, input int i, input logic [7:0] lo0);
        logic [63:0] w;
        w = {8'(ch), 8'(p), 16'hBEEF, 24'(i), 8'(i)};
        if (i == 0) w[7:0] = lo0;
        return w;
    endfunction

    task automatic send(input bit sop, input bit eop, input int ch, input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_chan = 3'(ch); in_data = d;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("send_timeout", 64'(n), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    // Sends n words; when push is set, expects them written with header [7:0]=n.
    task automatic send_pkt(input int ch, input int n, input int p, input logic [7:0] lo0, input bit push);
        for (int i = 0; i < n; i++) begin
            if (push) begin
                exp_t e;
                e.ch = 3'(ch);
                e.d  = word(ch, p, i, lo0);
                if (i == 0) e.d[7:0] = 8'(n);
                sbq.push_back(e);
            end
            send(i == 0, i == n - 1, ch, word(ch, p, i, lo0));
        end
        if (push) lenq.push_back(n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || run != 0) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("idle_timeout", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_drops(input string tag);
        chk({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
        chk({tag, "_err_pulses"}, 64'(err_cnt), 64'(exp_drop));
    endtask

    initial begin
        int k, t, saved;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wrreq", {56'd0, wrreq}, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        #1 chk("ready_at_release", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("ready_after_release", {63'd0, in_ready}, 64'd1);

        // 3-word packet to channel 5, empty FIFO: writes at edges k+2..k+4
        send_pkt(5, 3, 1, hdr_lo(3), 1'b1);
        k = cyc;
        wait_idle();
        chk("t1_first_wr", 64'(first_wr), 64'(k + 2));
        chk("t1_last_wr", 64'(last_wr), 64'(k + 4));

        // Channel 2 nearly full: held until free space equals the length
        usedw[2] = 10'd510;
        send_pkt(2, 4, 2, hdr_lo(4), 1'b1);
        saved = wr_total;
        repeat (8) @(negedge clk);
        chk("t2_held", 64'(wr_total), 64'(saved));
        usedw[2] = 10'd508;
        t = cyc;
        wait_idle();
        chk("t2_first_wr", 64'(first_wr), 64'(t + 2));
        chk("t2_last_wr", 64'(last_wr), 64'(t + 5));
        usedw[2] = '0;

        // Exactly one free slot, 1-word packet
        usedw[7] = 10'd511;
        send_pkt(7, 1, 3, hdr_lo(1), 1'b1);
        wait_idle();
        usedw[7] = '0;

        // Maximum-length packet is accepted
        send_pkt(0, 64, 4, hdr_lo(64), 1'b1);
        wait_idle();
        chk_drops("max_pkt");

        // Oversize packet dropped, next packet unaffected
        send_pkt(1, 65, 5, hdr_lo(65), 1'b0);
        exp_drop++;
        send_pkt(3, 2, 6, hdr_lo(2), 1'b1);
        wait_idle();
        chk_drops("oversize");

        // Non-sop word in IDLE, then sop mid-collection
        send(1'b0, 1'b0, 4, 64'h1234);
        exp_drop++;
        send(1'b1, 1'b0, 4, word(4, 7, 0, hdr_lo(2)));
        send(1'b0, 1'b0, 4, word(4, 7, 1, 8'h00));
        exp_drop++;
        send_pkt(6, 3, 8, hdr_lo(3), 1'b1);
        wait_idle();
        chk_drops("restart");

        // Declared length 4, actual 3
`ifdef FQ_INGRESS_LEN_CHECK_EN
        send_pkt(0, 3, 9, 8'd4, 1'b0);
        exp_drop++;
`else
        send_pkt(0, 3, 9, 8'd4, 1'b1);
`endif
        wait_idle();
        chk_drops("len_decl");

        // Reset while word 2 of a 5-word burst is on the bus
        send_pkt(2, 5, 10, hdr_lo(5), 1'b1);
        k = cyc;
        while (cyc < k + 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_wrreq", {56'd0, wrreq}, 64'd0);
        chk("rst_mid_drop", 64'(drop_count), 64'd0);
        chk("rst_mid_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(negedge clk);
        sbq.delete();
        lenq.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_after", {63'd0, in_ready}, 64'd1);

        // Normal operation after reset
        send_pkt(1, 2, 11, hdr_lo(2), 1'b1);
        wait_idle();
        chk("final_drop", 64'(drop_count), 64'd0);
        chk("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
